// File: rtl/bnn_param_loader.sv
// Sequencer for the tiny BNN core: shifts the parameter chain in from a byte stream, then runs samples as two nibbles.
// Optional macro BNN_LOADER_PARITY_EN builds an XOR accumulator of all shifted parameter bits.
module bnn_param_loader #(
  parameter int PARAM_BITS = 160,
  parameter int CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_load,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready,
  output logic       loaded,
  output logic       cfg_parity,
  output logic       bnn_clk,
  output logic       bnn_setup,
  output logic       bnn_param,
  output logic       bnn_bank_hi,
  output logic [3:0] bnn_x,
  input  logic [7:0] bnn_out
);
  localparam int BW = $clog2(PARAM_BITS + 1);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(PARAM_BITS);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_FETCH, LOAD_SHIFT, RUN_LO, RUN_HI, SETTLE, RESULT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            clk_q, clk_d;
  logic [BW-1:0]   bits_q, bits_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      sr_q, sr_d;
  logic [3:0]      hi_q, hi_d;
  logic            loaded_q, loaded_d;
  logic            setup_q, setup_d;
  logic            bank_q, bank_d;
  logic [3:0]      x_q, x_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;

  logic in_tick, cnt_last, tick_end;

  assign in_tick  = (state_q == LOAD_SHIFT) || (state_q == RUN_LO) || (state_q == RUN_HI);
  assign cnt_last = (cnt_q == DIV_LAST);
  assign tick_end = in_tick && clk_q && cnt_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_q       <= 1'b0;
      bits_q      <= '0;
      bidx_q      <= '0;
      sr_q        <= '0;
      hi_q        <= '0;
      loaded_q    <= 1'b0;
      setup_q     <= 1'b0;
      bank_q      <= 1'b0;
      x_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_q       <= clk_d;
      bits_q      <= bits_d;
      bidx_q      <= bidx_d;
      sr_q        <= sr_d;
      hi_q        <= hi_d;
      loaded_q    <= loaded_d;
      setup_q     <= setup_d;
      bank_q      <= bank_d;
      x_q         <= x_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clk_d       = clk_q;
    bits_d      = bits_q;
    bidx_d      = bidx_q;
    sr_d        = sr_q;
    hi_d        = hi_q;
    loaded_d    = loaded_q;
    setup_d     = setup_q;
    bank_d      = bank_q;
    x_d         = x_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    // Shared tick engine: CLK_DIV low cycles, then CLK_DIV high cycles.
    if (in_tick) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
      if (cnt_last) clk_d = ~clk_q;
    end

    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d  = LOAD_FETCH;
          loaded_d = 1'b0;
          bits_d   = '0;
          bidx_d   = '0;
        end else if (loaded_q && in_valid && !res_valid_q) begin
          state_d = RUN_LO;
          setup_d = 1'b0;
          bank_d  = 1'b0;
          x_d     = in_data[3:0];
          hi_d    = in_data[7:4];
          cnt_d   = '0;
          clk_d   = 1'b0;
        end
      end
      LOAD_FETCH: begin
        if (cfg_valid) begin
          state_d = LOAD_SHIFT;
          sr_d    = cfg_data;
          setup_d = 1'b1;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end
      end
      LOAD_SHIFT: begin
        // sr_q[0] drives bnn_param, so shifting on the falling cycle presents the next bit.
        if (tick_end) begin
          bits_d = bits_q + 1'b1;
          bidx_d = bidx_q + 3'd1;
          sr_d   = sr_q >> 1;
          if (bits_d == BITS_LAST) begin
            state_d  = IDLE;
            loaded_d = 1'b1;
            setup_d  = 1'b0;
            sr_d     = '0;
          end else if (bidx_d == 3'd0) begin
            state_d = LOAD_FETCH;
          end
        end
      end
      RUN_LO: begin
        if (tick_end) begin
          state_d = RUN_HI;
          bank_d  = 1'b1;
          x_d     = hi_q;
        end
      end
      RUN_HI: begin
        if (tick_end) state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d       = '0;
          res_data_d  = bnn_out;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BNN_LOADER_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      par_q <= 1'b0;
    else if (state_q == IDLE && start_load)       par_q <= 1'b0;
    else if (state_q == LOAD_SHIFT && tick_end)   par_q <= par_q ^ sr_q[0];
  end
  assign cfg_parity = par_q;
`else
  assign cfg_parity = 1'b0;
`endif

  assign cfg_ready   = (state_q == LOAD_FETCH);
  assign in_ready    = (state_q == IDLE) && loaded_q && !res_valid_q && !start_load;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign loaded      = loaded_q;
  assign bnn_clk     = clk_q;
  assign bnn_setup   = setup_q;
  assign bnn_param   = sr_q[0];
  assign bnn_bank_hi = bank_q;
  assign bnn_x       = x_q;
endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Upstream sequencer for the tiny BNN core.
- Takes a byte-wide configuration stream and a byte-wide sample stream on the system clock.
- Drives the core's slow user-clock pins: user clock, setup, param bit, bank select and nibble.
- Serially loads the parameter chain, feeds each 8-bit sample as two nibbles, then captures the 8-bit network output into a result handshake.

Parameters:
PARAM_BITS, 160, total bits in the downstream parameter chain; bits shifted per load.
CLK_DIV, 4, system-clock cycles per half-period of the generated user clock (min 1).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start_load  in  1  one-cycle pulse; begins a parameter load (honoured in IDLE only)
cfg_valid  in  1  config byte valid
cfg_data  in  8  config byte, consumed LSB first
cfg_ready  out  1  config byte accepted when cfg_valid & cfg_ready
in_valid  in  1  sample valid
in_data  in  8  sample (bits 3:0 low bank, 7:4 high bank)
in_ready  out  1  sample accepted when in_valid & in_ready
res_valid  out  1  result available
res_data  out  8  captured network output
res_ready  in  1  result consumed when res_valid & res_ready
loaded  out  1  parameter chain holds a complete load
cfg_parity  out  1  XOR of all loaded bits (see Optional Feature)
bnn_clk  out  1  generated user clock to the core
bnn_setup  out  1  core setup line
bnn_param  out  1  serial parameter bit into the chain
bnn_bank_hi  out  1  nibble bank select
bnn_x  out  4  nibble value
bnn_out  in  8  core output bits

Behaviour:
- Reset values: all outputs 0, state IDLE, tick counter 0.
- Tick definition: bnn_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
- bnn_setup, bnn_param, bnn_bank_hi and bnn_x change only on the cycle bnn_clk falls, or on the first low cycle of a tick. They are stable across every rising edge.
- Between ticks, bnn_clk idles low.
- States: IDLE, LOAD_FETCH, LOAD_SHIFT, RUN_LO, RUN_HI, SETTLE, RESULT.
- IDLE:
  - start_load: go to LOAD_FETCH, clear loaded, clear bit count.
  - Otherwise, if loaded & in_valid & !res_valid: accept the sample and go to RUN_LO.
  - If start_load and in_valid arrive in the same cycle, start_load wins; in_ready stays 0.
- in_ready is 1 only in IDLE with loaded=1, res_valid=0, start_load=0.
- LOAD_FETCH:
  - cfg_ready=1; wait for cfg_valid. bnn_clk stays low while starved.
  - On accept: latch the byte and go to LOAD_SHIFT.
- LOAD_SHIFT:
  - bnn_setup=1. For each bit, LSB first: bnn_param=bit, then one tick.
  - After 8 bits: return to LOAD_FETCH.
  - After PARAM_BITS total bits: go to IDLE, set loaded=1. Unused upper bits of the final byte are discarded.
  - Bytes required = ceil(PARAM_BITS/8).
- RUN_LO: bnn_setup=0, bnn_bank_hi=0, bnn_x=sample[3:0]; one tick.
- RUN_HI: bnn_bank_hi=1, bnn_x=sample[7:4]; one tick.
- SETTLE: wait CLK_DIV cycles with bnn_clk low, then register bnn_out into res_data, set res_valid, go to RESULT.
- RESULT:
  - res_valid and res_data are held until res_ready; then res_valid=0 and go to IDLE.
  - res_ready in the same cycle as capture is not honoured until the next cycle.
- bnn_setup returns to 0 on entering IDLE. The core's global inputs are left zeroed by the load.
- start_load outside IDLE is ignored (no queueing).
- Reset mid-load or mid-run: immediate return to reset values. loaded=0, bnn_clk low, partial byte discarded.
- Bit counter width: clog2(PARAM_BITS+1). Half-period counter width: clog2(CLK_DIV+1). No wrap before the terminal count.

Optional Feature:
- Macro BNN_LOADER_PARITY_EN.
- Defined:
  - cfg_parity accumulates the XOR of every bnn_param bit shifted during LOAD_SHIFT.
  - It clears on start_load and is valid when loaded=1.
- Undefined: cfg_parity is tied 0 and no accumulator flop is built.

Test Plan:
- Load, PARAM_BITS=12, CLK_DIV=2: bytes 0xA5, 0x3C -> 12 rising edges of bnn_clk with bnn_setup=1. bnn_param at the edges is 1,0,1,0,0,1,0,1,0,0,1,1. loaded=1 after the 48th load-phase cycle. cfg_parity=0 with the macro defined.
- Inference: in_data=0x7E with bnn_out tied 0x5A -> one edge with bank_hi=0, x=0xE, then one edge with bank_hi=1, x=0x7. res_valid=1 with res_data=0x5A, held 3 cycles until res_ready, then cleared.
- Starvation: insert 10 idle cycles between the two config bytes -> bnn_clk stays low for that gap and the bit sequence is unchanged.
- Gating: in_valid=1 before any load -> in_ready=0. The same in the cycle start_load=1. A second sample with res_valid pending -> in_ready=0 until the result is taken.
- Reset mid-load: assert rst after 5 shifted bits -> all outputs 0 immediately. The next full load produces the correct 12-bit sequence.
- start_load during RUN_HI -> ignored; the result is delivered normally and loaded stays 1.
